// File: rtl/if_prefetch_queue_pkg.sv
// Shared fetch-stage definitions: widths, reset PC default and the
// prefetch queue entry layout.
package if_prefetch_queue_pkg;

   localparam int unsigned AW_DEF = 32;
   localparam int unsigned INST_W = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Entry layout, LSB first: misalign, inst, pc4, pc
   localparam int unsigned MIS_LSB  = 0;
   localparam int unsigned INST_LSB = 1;
   localparam int unsigned PC4_LSB  = INST_LSB + INST_W;

   function automatic int unsigned pc_lsb(input int unsigned aw);
      return PC4_LSB + aw;
   endfunction

   function automatic int unsigned entry_w(input int unsigned aw);
      return PC4_LSB + 2 * aw;
   endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bus bundle: IMEM request/response, MEM redirect and the
// decode-side valid/ready head.
interface if_prefetch_queue_if #(
   parameter int unsigned AW    = if_prefetch_queue_pkg::AW_DEF,
   parameter int unsigned DEPTH = 4
);

   logic                    MEM_PCSrc;
   logic [AW-1:0]           MEM_Btarg_or_Jtarg;
   logic                    imem_req;
   logic [AW-1:0]           imem_addr;
   logic [31:0]             imem_rdata;
   logic                    out_valid;
   logic                    out_ready;
   logic [AW-1:0]           out_pc;
   logic [AW-1:0]           out_pc4;
   logic [31:0]             out_inst;
   logic                    out_misalign;
   logic [$clog2(DEPTH):0]  count;

   modport master (
      input  MEM_PCSrc, MEM_Btarg_or_Jtarg, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_pc, out_pc4, out_inst,
             out_misalign, count
   );

   modport slave (
      output MEM_PCSrc, MEM_Btarg_or_Jtarg, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_pc, out_pc4, out_inst,
             out_misalign, count
   );

endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// DEPTH x WIDTH synchronous FIFO with synchronous clear and wrap-bit
// pointers; head is read straight from storage.
module if_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   Clk,
   input  logic                   Clr,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned PTRW = PW + 1;

   logic [PW:0]      wptr, rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             full;

   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign head  = mem[rptr[PW-1:0]];

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTRW'(1);
         if (pop)  rptr <= rptr + PTRW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !clear) begin
         mem[wptr[PW-1:0]] <= wdata;
      end
   end

   a_no_push_when_full: assert property (@(posedge Clk) disable iff (Clr)
      !(push && full && !clear));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch with decoupled prefetch queue: one IMEM request per cycle
// while space remains, {pc, pc4, inst, misalign} buffered for decode.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int unsigned   DEPTH    = 4,
   parameter int unsigned   AW       = AW_DEF,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
   input logic                 Clk,
   input logic                 Clr,
   if_prefetch_queue_if.master bus
);

   localparam int unsigned CW     = $clog2(DEPTH) + 1;
   localparam int unsigned OW     = CW + 1;
   localparam int unsigned EW     = entry_w(AW);
   localparam int unsigned PC_LSB = pc_lsb(AW);

   logic [AW-1:0] fetch_pc;
   logic [AW-1:0] inflight_pc;
   logic          inflight;
   logic          push, pop, empty;
   logic [CW-1:0] count;
   logic [OW-1:0] occ;
   logic [EW-1:0] wr_entry, head;

   assign pop  = ~empty & bus.out_ready & ~bus.MEM_PCSrc;
   assign push = inflight & ~bus.MEM_PCSrc;

   // Slots already committed (stored + outstanding) after this cycle's pop
   assign occ = {1'b0, count} + OW'(inflight) - OW'(pop);

   assign bus.imem_req  = ~Clr & (bus.MEM_PCSrc | (occ < OW'(DEPTH)));
   assign bus.imem_addr = bus.MEM_PCSrc ? bus.MEM_Btarg_or_Jtarg : fetch_pc;

   assign wr_entry = {inflight_pc, inflight_pc + AW'(4), bus.imem_rdata,
                      |inflight_pc[1:0]};

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (bus.MEM_PCSrc) begin
         inflight    <= 1'b1;
         inflight_pc <= bus.MEM_Btarg_or_Jtarg;
         fetch_pc    <= bus.MEM_Btarg_or_Jtarg + AW'(4);
      end else begin
         inflight <= bus.imem_req;
         if (bus.imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + AW'(4);
         end
      end
   end

   if_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .Clk   (Clk),
      .Clr   (Clr),
      .clear (bus.MEM_PCSrc),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .head  (head),
      .count (count),
      .empty (empty)
   );

   assign bus.out_valid    = ~empty;
   assign bus.count        = count;
   assign bus.out_pc       = head[PC_LSB +: AW];
   assign bus.out_pc4      = head[PC4_LSB +: AW];
   assign bus.out_inst     = head[INST_LSB +: INST_W];
   assign bus.out_misalign = head[MIS_LSB];

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch stage with a decoupled prefetch queue, successor to the single-register IF stage. It drives a synchronous instruction memory one word per cycle and buffers fetched {PC, PC+4, instruction} entries in a DEPTH-entry FIFO. Decode consumes entries via a valid/ready handshake. A taken branch or jump redirect from MEM flushes the queue and any in-flight fetch. It sits between the PC/IMEM and the IF/ID boundary, and replaces the stall-hold register.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `AW`, 32: PC/address width.
- `Clk  in  1`: clock; all state updates on the rising edge.
- `Clr  in  1`: asynchronous active-high reset.
- `MEM_PCSrc  in  1`: redirect request; 1 = taken branch/jump.
- `MEM_Btarg_or_Jtarg  in  AW`: redirect target.
- `imem_req  out  1`: fetch issued this cycle.
- `imem_addr  out  AW`: fetch address; combinational.
- `imem_rdata  in  32`: instruction, valid in the cycle after `imem_req`. Fixed latency 1, no backpressure.
- `out_valid  out  1`: queue head valid.
- `out_ready  in  1`: decode accepts the head.
- `out_pc  out  AW`: PC of the head entry.
- `out_pc4  out  AW`: PC+4 of the head entry.
- `out_inst  out  32`: instruction of the head entry.
- `out_misalign  out  1`: head PC has bits [1:0] ≠ 0.
- `count  out  log2(DEPTH)+1`: current occupancy.

## Operation
- State:
  - `fetch_pc`: next address to issue.
  - `inflight` and `inflight_pc`: request outstanding, and its address.
  - FIFO storage with read/write pointers; each pointer carries one extra wrap bit.
- Pop: `pop = out_valid & out_ready & ~MEM_PCSrc`.
- Issue rule, no redirect: `imem_req = (count + inflight − pop) < DEPTH`; then `imem_addr = fetch_pc`. On issue, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^AW).
- Push: when `inflight & ~MEM_PCSrc`, write entry {`inflight_pc`, `inflight_pc + 4`, `imem_rdata`, `inflight_pc[1:0] != 0`}. The issue rule guarantees a push never finds the queue full. A push when full is an assertion failure.
- Redirect (`MEM_PCSrc = 1`), all in the same cycle:
  - Clear the FIFO: pointers to 0, count to 0.
  - Discard the response arriving this cycle; no push.
  - Ignore `out_ready`.
  - Issue unconditionally: `imem_req = 1`, `imem_addr = MEM_Btarg_or_Jtarg`.
  - Update: `inflight <= 1`, `inflight_pc <= target`, `fetch_pc <= target + 4`.
- A misaligned target is fetched as given (IMEM uses word address `addr[AW-1:2]`). It is only flagged through `out_misalign`; it is never trapped here.
- Push and pop in the same cycle: `count` unchanged, and both pointers advance.
- Empty queue with a push: the entry becomes visible at the next edge. There is no bypass to the output.
- Reset (`Clr = 1`, asynchronous, also mid-operation):
  - `fetch_pc = RESET_PC`, `inflight = 0`, pointers = 0, `count = 0`.
  - `imem_req = 0` while `Clr` is high.
  - `out_valid = 0`.
  - `out_pc`, `out_pc4`, `out_inst`, `out_misalign` read storage entry 0, which resets to all-zero.
  - Any in-flight response is lost.

## Timing
- First request: in the first cycle after `Clr` falls, at `RESET_PC`. Data is pushed at the end of the next cycle, so `out_valid = 1` two cycles after reset release.
- Fetch-to-output latency: 2 cycles from issue to `out_valid`.
- Redirect-to-output latency: 2 cycles. Redirect in cycle t gives the target at the head in t+2.
- Steady-state throughput: 1 instruction/cycle with `out_ready` held high, for any `DEPTH` ≥ 2.
- Backpressure: with `out_ready = 0`, issue stops once `count + inflight = DEPTH`. Issue resumes in the same cycle as the first pop.
- Outputs `out_*` come from registers and storage. `imem_addr` and `imem_req` are combinational from state plus `MEM_PCSrc` and `out_ready`.

## Structure
- Shared `cpu_pkg` (or header): `AW`, the instruction width (32), `RESET_PC` default, and the queue-entry width and field offsets {pc, pc4, inst, misalign}.
- Sub-module `if_fifo`:
  - Parametrised DEPTH×WIDTH synchronous FIFO with `clear`, `push`, `pop`, `count`, and a head output.
  - Wrap-bit full/empty detection.
  - Reusable later for the store buffer.

## Test plan
- **Reset and stream:** `RESET_PC = 0x0`, IMEM returns `0x1000_0000 + addr`, `out_ready = 1`. Required: first `out_valid` 2 cycles after reset; heads 0x0, 0x4, 0x8… back-to-back; `out_pc4 = out_pc + 4`.
- **Backpressure:** `DEPTH = 4`, `out_ready = 0` for 10 cycles. Required: `count` saturates at 4; `imem_req` low once `count + inflight = 4`. After release, entries drain in order with no loss or duplicate.
- **Redirect:** in the cycle the head is 0x8 with `count = 3`, assert `MEM_PCSrc` with target 0x40. Required: `count → 0`; the response for the old in-flight address is dropped; `imem_addr = 0x40` in that cycle; head 0x40 two cycles later, then 0x44.
- **Simultaneous redirect and pop:** `out_ready = 1` plus a redirect to 0x100. Required: no pop is counted; the next accepted head is 0x100.
- **Misaligned target:** redirect to 0x42. Required: `out_pc = 0x42`, `out_misalign = 1`, `out_pc4 = 0x46`; the following entry is 0x46, still with `out_misalign = 1`.
- **Reset mid-stream:** assert `Clr` asynchronously with `count = 2` and a fetch in flight. Required: outputs clear immediately without waiting for an edge; refetch restarts at `RESET_PC`; no stale instruction appears.
